// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial add/sub controller family.
// Holds the FSM state encoding and the default operand width.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, with borrow-out.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one fs_cell time-shared over WIDTH bits, LSB first.
// start is sampled only in IDLE; done pulses one cycle when diff/borrow_out are loaded.
module serial_sub_ctrl
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output state_t           state
);

   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [CNT_W-1:0] cnt;
   logic             brw;
   logic             cell_d;
   logic             cell_bo;
   logic             last;

   fs_cell u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (brw),
      .diff (cell_d),
      .bout (cell_bo)
   );

   assign last = (cnt == CNT_W'(WIDTH - 1));
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Result bits enter at the MSB so after WIDTH shifts the LSB-first stream is aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         cnt        <= '0;
         brw        <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  cnt    <= '0;
                  brw    <= 1'b0;
               end
            end
            RUN: begin
               res_sr <= {cell_d, res_sr[WIDTH-1:1]};
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               brw    <= cell_bo;
               cnt    <= cnt + CNT_W'(1);
               if (last) begin
                  diff       <= {cell_d, res_sr[WIDTH-1:1]};
                  borrow_out <= cell_bo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random bench for serial_sub_ctrl (WIDTH=8) with an expected-result queue.
module tb_serial_sub_ctrl;
   import sub_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   state_t       state;

   logic [W:0]   exp_q[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           done_cnt = 0;
   logic         done_q = 1'b0;
   logic         mon_en = 1'b0;
   logic [31:0]  mon_e;

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .state      (state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      return {1'b0, x} - {1'b0, y};
   endfunction

   // Monitor: every done pops one expected {borrow_out, diff}.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy_vs_state", 32'(busy), 32'(state != IDLE));
         if (done) begin
            chk("done_width", 32'(done_q), 32'd0);
            mon_e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
            chk("result", 32'({borrow_out, diff}), mon_e);
            done_cnt++;
         end
         done_q = done;
      end
   end

   // Called at a negedge with the DUT in IDLE; returns done latency and busy length.
   task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output int lat, output int busy_n);
      start = 1'b1;
      a = aa;
      b = bb;
      exp_q.push_back(model(aa, bb));
      lat = 0;
      busy_n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
         end
         if (busy) busy_n++;
         if (done && lat == 0) lat = i;
         if (!busy) break;
      end
   endtask

   initial begin
      int lat, busy_n, pos1, pos2, ndone, saved;
      logic [W-1:0] ra, rb;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow_out), 32'd0);
      chk("rst_state", 32'(state), 32'(IDLE));
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      run_op(8'h5A, 8'h3C, lat, busy_n);
      chk("lat_5a", 32'(lat), 32'd9);
      chk("busy_len_5a", 32'(busy_n), 32'd9);
      chk("diff_5a", 32'(diff), 32'h1E);
      chk("borrow_5a", 32'(borrow_out), 32'd0);

      run_op(8'h00, 8'h01, lat, busy_n);
      chk("diff_00_01", 32'(diff), 32'hFF);
      chk("borrow_00_01", 32'(borrow_out), 32'd1);
      run_op(8'hFF, 8'hFF, lat, busy_n);
      chk("diff_ff_ff", 32'(diff), 32'h00);
      chk("borrow_ff_ff", 32'(borrow_out), 32'd0);

      // start held high: two operations back to back.
      start = 1'b1;
      a = 8'h10;
      b = 8'h01;
      exp_q.push_back(model(8'h10, 8'h01));
      pos1 = 0;
      pos2 = 0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (i == 1) begin
            a = 8'h01;
            b = 8'h10;
            exp_q.push_back(model(8'h01, 8'h10));
         end
         if (i == 11) start = 1'b0;
         if (done && pos1 == 0) pos1 = i;
         else if (done && pos2 == 0) pos2 = i;
      end
      chk("held_first_done", 32'(pos1), 32'd9);
      chk("held_period", 32'(pos2 - pos1), 32'd10);
      chk("held_diff2", 32'(diff), 32'hF1);
      chk("held_borrow2", 32'(borrow_out), 32'd1);

      // start pulsed mid-RUN must be ignored.
      start = 1'b1;
      a = 8'h80;
      b = 8'h01;
      exp_q.push_back(model(8'h80, 8'h01));
      ndone = 0;
      pos1 = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 3) begin
            start = 1'b1;
            a = 8'h00;
            b = 8'hFF;
         end
         if (i == 4) begin
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
         end
         if (done) begin
            ndone++;
            if (pos1 == 0) pos1 = i;
         end
      end
      chk("ignore_ndone", 32'(ndone), 32'd1);
      chk("ignore_pos", 32'(pos1), 32'd9);
      chk("ignore_diff", 32'(diff), 32'h7F);
      chk("ignore_borrow", 32'(borrow_out), 32'd0);

      // Reset in cycle 4 of RUN aborts the operation.
      start = 1'b1;
      a = 8'h33;
      b = 8'h11;
      saved = done_cnt;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 4) rst = 1'b1;
      end
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_state", 32'(state), 32'(IDLE));
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_borrow", 32'(borrow_out), 32'd0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'(saved));
      run_op(8'h33, 8'h11, lat, busy_n);
      chk("after_abort_lat", 32'(lat), 32'd9);
      chk("after_abort_diff", 32'(diff), 32'h22);

      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         run_op(ra, rb, lat, busy_n);
         chk("rand_lat", 32'(lat), 32'd9);
      end

      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
